// File: rtl/fifo_pkg.sv
// Shared constants for my_fifo and its downstream stream bridge.
// Helper sizes the burst position counter.
package fifo_pkg;

  localparam int FIFO_DATA_W = 128;

  function automatic int beat_idx_w(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/fifo_stream_bridge_if.sv
// FIFO read-port and output-stream signals of fifo_stream_bridge.
// master = bridge side, slave = FIFO + consumer side.
interface fifo_stream_bridge_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int CNT_W  = 32
);

  logic              o_fifo_rden;
  logic [DATA_W-1:0] i_fifo_rddata;
  logic              i_fifo_empty;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_last;
  logic              i_ready;
  logic              i_flush;
  logic [CNT_W-1:0]  o_beat_total;

  modport master (
    output o_fifo_rden,
    input  i_fifo_rddata,
    input  i_fifo_empty,
    output o_valid,
    output o_data,
    output o_last,
    input  i_ready,
    input  i_flush,
    output o_beat_total
  );

  modport slave (
    input  o_fifo_rden,
    output i_fifo_rddata,
    output i_fifo_empty,
    input  o_valid,
    input  o_data,
    input  o_last,
    output i_ready,
    output i_flush,
    input  o_beat_total
  );

endinterface

// File: rtl/fifo_stream_bridge_skid.sv
// Two-entry skid buffer: registered valid/data, push lands in first free slot after accept.
// Output valid one cycle after push; holds data stable while the consumer stalls.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              rdy,
  output logic              vld,
  output logic [DATA_W-1:0] dat,
  output logic              acc,
  output logic [1:0]        cnt
);

  logic [DATA_W-1:0] buf_q [2];
  logic [1:0]        buf_cnt;
  logic [1:0]        cnt_after_acc;

  assign vld           = (buf_cnt != 2'd0);
  assign acc           = vld & rdy;
  assign dat           = buf_q[0];
  assign cnt           = buf_cnt;
  assign cnt_after_acc = buf_cnt - {1'b0, acc};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      buf_cnt  <= 2'd0;
    end else begin
      if (flush) begin
        buf_cnt <= 2'd0;
      end else begin
        buf_cnt <= cnt_after_acc + {1'b0, push};
      end
      if (acc) begin
        buf_q[0] <= buf_q[1];
      end
      // A push after the head leaves must overwrite the shifted head slot.
      if (push) begin
        if (cnt_after_acc == 2'd0) begin
          buf_q[0] <= push_dat;
        end else begin
          buf_q[1] <= push_dat;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_stream_bridge.sv
// Drains a show-ahead FIFO into a registered valid/ready stream framed in BURST_LEN-beat bursts.
// One cycle pop-to-valid; pop depends only on buffer occupancy, so i_ready never reaches o_fifo_rden.
module fifo_stream_bridge
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  fifo_stream_bridge_if.master bus
);

  localparam int               IDX_W    = beat_idx_w(BURST_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  logic              push;
  logic              acc;
  logic              valid;
  logic [1:0]        buf_cnt;
  logic [DATA_W-1:0] data;
  logic [IDX_W-1:0]  beat_idx;
  logic [CNT_W-1:0]  beat_total;

  assign push = rstn & ~bus.i_flush & ~bus.i_fifo_empty & (buf_cnt != 2'd2);

  stream_skid_buf #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (bus.i_flush),
    .push    (push),
    .push_dat(bus.i_fifo_rddata),
    .rdy     (bus.i_ready),
    .vld     (valid),
    .dat     (data),
    .acc     (acc),
    .cnt     (buf_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      beat_idx <= '0;
    end else if (bus.i_flush) begin
      beat_idx <= '0;
    end else if (acc) begin
      beat_idx <= (beat_idx == LAST_IDX) ? '0 : beat_idx + 1'b1;
    end
  end

  // Beats accepted in a flush cycle still count here.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      beat_total <= '0;
    end else if (acc && (beat_total != '1)) begin
      beat_total <= beat_total + 1'b1;
    end
  end

  assign bus.o_fifo_rden  = push;
  assign bus.o_valid      = valid;
  assign bus.o_data       = data;
  assign bus.o_last       = valid & (beat_idx == LAST_IDX);
  assign bus.o_beat_total = beat_total;

endmodule
